// File: rtl/adder_pkg.sv
// Shared operation encoding and segment sizing helpers for the pipelined adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_NUM_STAGES = 2;

  // Bits handled by one pipeline segment; falls back to WIDTH for an illegal stage count.
  function automatic int seg_width(input int width, input int num_stages);
    return (num_stages < 1) ? width : width / num_stages;
  endfunction

  function automatic bit stage_cfg_ok(input int width, input int num_stages);
    if (num_stages < 1) return 1'b0;
    return (width % num_stages) == 0;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple segment; also reports the carry into its top bit.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign sum   = full[SEG-1:0];
  assign cout  = full[SEG];
  // The top sum bit is a^b^carry_in, so the incoming carry falls out of an XOR.
  assign c_msb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub with the carry chain cut into NUM_STAGES registered segments.
// Upper operand bits and op ride along in skew registers; finished low sum bits move forward.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SEG  = seg_width(WIDTH, NUM_STAGES);
  localparam int LAST = (NUM_STAGES < 1) ? 0 : NUM_STAGES - 1;

  if (!stage_cfg_ok(WIDTH, NUM_STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of NUM_STAGES (%0d >= 1)",
           WIDTH, NUM_STAGES);
  end

  // Handshake: a beat enters when in_valid && in_ready and leaves when out_valid && out_ready.
  // The whole pipe moves on adv; it freezes only while a result waits on a busy consumer,
  // so in_ready is that same enable and no beat is dropped, duplicated or reordered.
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SEG;

    logic            in_v;
    logic            op_in;
    logic [SEG-1:0]  a_seg;
    logic [SEG-1:0]  b_raw;
    logic [SEG-1:0]  b_seg;
    logic            c_in;
    logic [SEG-1:0]  s_seg;
    logic            c_out;
    logic            c_msb;
    logic [DONE-1:0] sum_d;
    logic            valid_q;
    logic            carry_q;
    logic [DONE-1:0] sum_q;

    if (k == 0) begin : g_src
      assign in_v  = in_valid;
      assign op_in = (op == OP_SUB);
      assign a_seg = a[SEG-1:0];
      assign b_raw = b[SEG-1:0];
      assign c_in  = op_in ? 1'b1 : cin;
      assign sum_d = s_seg;
    end else begin : g_src
      assign in_v  = g_stage[k-1].valid_q;
      assign op_in = g_stage[k-1].g_skew.op_q;
      assign a_seg = g_stage[k-1].g_skew.a_rem[SEG-1:0];
      assign b_raw = g_stage[k-1].g_skew.b_rem[SEG-1:0];
      assign c_in  = g_stage[k-1].carry_q;
      assign sum_d = {s_seg, g_stage[k-1].sum_q};
    end

    assign b_seg = op_in ? ~b_raw : b_raw;

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a     (a_seg),
      .b     (b_seg),
      .cin   (c_in),
      .sum   (s_seg),
      .cout  (c_out),
      .c_msb (c_msb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= in_v;
        if (in_v) begin
          sum_q   <= sum_d;
          carry_q <= c_out;
        end
      end
    end

    // Operand bits not yet consumed, shifted down so the next segment always reads bit 0 up.
    if (k < NUM_STAGES - 1) begin : g_skew
      localparam int REM = WIDTH - DONE;

      logic [REM-1:0] a_nxt;
      logic [REM-1:0] b_nxt;
      logic [REM-1:0] a_rem;
      logic [REM-1:0] b_rem;
      logic           op_q;

      if (k == 0) begin : g_take
        assign a_nxt = a[WIDTH-1:SEG];
        assign b_nxt = b[WIDTH-1:SEG];
      end else begin : g_take
        localparam int PREV_REM = WIDTH - k * SEG;
        assign a_nxt = g_stage[k-1].g_skew.a_rem[PREV_REM-1:SEG];
        assign b_nxt = g_stage[k-1].g_skew.b_rem[PREV_REM-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem <= '0;
          b_rem <= '0;
          op_q  <= 1'b0;
        end else if (adv && in_v) begin
          a_rem <= a_nxt;
          b_rem <= b_nxt;
          op_q  <= op_in;
        end
      end
    end

    if (k == NUM_STAGES - 1) begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && in_v) begin
          ovf_q <= c_msb ^ c_out;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].valid_q;
  assign sum       = g_stage[LAST].sum_q;
  assign carry     = g_stage[LAST].carry_q;
  assign overflow  = g_stage[LAST].g_last.ovf_q;

  // A result presented to a stalled consumer must stay put until taken.
  property p_hold_under_stall;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=>
        (out_valid && $stable(sum) && $stable(carry) && $stable(overflow));
  endproperty
  a_hold_under_stall: assert property (p_hold_under_stall);

  property p_ready_is_enable;
    @(posedge clk) disable iff (rst) in_ready == (!out_valid || out_ready);
  endproperty
  a_ready_is_enable: assert property (p_ready_is_enable);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder in 8/2, 32/4 and 8/1 configurations.
module tb_pipelined_adder;
  import adder_pkg::*;

  logic clk;
  logic rst;

  logic        v8_in_valid, v8_in_ready, v8_cin, v8_out_valid, v8_out_ready, v8_carry, v8_overflow;
  logic [7:0]  v8_a, v8_b, v8_sum;
  op_e         v8_op;

  logic        w32_in_valid, w32_in_ready, w32_cin, w32_out_valid, w32_out_ready, w32_carry, w32_overflow;
  logic [31:0] w32_a, w32_b, w32_sum;
  op_e         w32_op;

  logic        s1_in_valid, s1_in_ready, s1_cin, s1_out_valid, s1_out_ready, s1_carry, s1_overflow;
  logic [7:0]  s1_a, s1_b, s1_sum;
  op_e         s1_op;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(8), .NUM_STAGES(2)) u_v8 (
    .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .a(v8_a), .b(v8_b), .cin(v8_cin), .op(v8_op),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .sum(v8_sum), .carry(v8_carry), .overflow(v8_overflow)
  );

  pipelined_adder #(.WIDTH(32), .NUM_STAGES(4)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
    .a(w32_a), .b(w32_b), .cin(w32_cin), .op(w32_op),
    .out_valid(w32_out_valid), .out_ready(w32_out_ready),
    .sum(w32_sum), .carry(w32_carry), .overflow(w32_overflow)
  );

  pipelined_adder #(.WIDTH(8), .NUM_STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .cin(s1_cin), .op(s1_op),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .sum(s1_sum), .carry(s1_carry), .overflow(s1_overflow)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference models: {carry, overflow, sum}
  function automatic logic [9:0] ref8(input logic [7:0] fa, input logic [7:0] fb,
                                      input logic fc, input op_e fo);
    logic [7:0] bp;
    logic       ci;
    logic [8:0] full;
    logic       ov;
    bp   = (fo == OP_SUB) ? ~fb : fb;
    ci   = (fo == OP_SUB) ? 1'b1 : fc;
    full = {1'b0, fa} + {1'b0, bp} + {8'b0, ci};
    ov   = (fa[7] == bp[7]) && (full[7] != fa[7]);
    return {full[8], ov, full[7:0]};
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] fa, input logic [31:0] fb,
                                        input logic fc, input op_e fo);
    logic [31:0] bp;
    logic        ci;
    logic [32:0] full;
    logic        ov;
    bp   = (fo == OP_SUB) ? ~fb : fb;
    ci   = (fo == OP_SUB) ? 1'b1 : fc;
    full = {1'b0, fa} + {1'b0, bp} + {32'b0, ci};
    ov   = (fa[31] == bp[31]) && (full[31] != fa[31]);
    return {full[32], ov, full[31:0]};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (v8_out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", v8_out_valid); end
    checks++;
    if (v8_sum !== 8'h00) begin errors++; $display("FAIL reset sum: got %h want 00", v8_sum); end
    checks++;
    if (v8_carry !== 1'b0) begin errors++; $display("FAIL reset carry: got %b want 0", v8_carry); end
    checks++;
    if (v8_overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", v8_overflow); end
    checks++;
    if (w32_out_valid !== 1'b0 || s1_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset other out_valid: got %b/%b want 0/0", w32_out_valid, s1_out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (v8_in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", v8_in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input logic vcin, input op_e vop,
                             input logic [7:0] es, input logic ec, input logic ev);
    int lat;
    @(negedge clk);
    v8_a = va; v8_b = vb; v8_cin = vcin; v8_op = vop;
    v8_in_valid = 1'b1; v8_out_ready = 1'b1;
    #1;
    checks++;
    if (v8_in_ready !== 1'b1) begin errors++; $display("FAIL %s accept: in_ready=%b want 1", name, v8_in_ready); end
    @(negedge clk);
    v8_in_valid = 1'b0; v8_a = 8'h00; v8_b = 8'h00; v8_cin = 1'b0; v8_op = OP_ADD;
    lat = 1;
    #1;
    while (v8_out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (v8_out_valid !== 1'b1 || lat != 2) begin
      errors++; $display("FAIL %s latency: got %0d (out_valid=%b) want 2", name, lat, v8_out_valid);
    end
    checks++;
    if (v8_sum !== es) begin errors++; $display("FAIL %s sum: got %h want %h", name, v8_sum, es); end
    checks++;
    if (v8_carry !== ec) begin errors++; $display("FAIL %s carry: got %b want %b", name, v8_carry, ec); end
    checks++;
    if (v8_overflow !== ev) begin errors++; $display("FAIL %s overflow: got %b want %b", name, v8_overflow, ev); end
    @(negedge clk);
    #1;
    checks++;
    if (v8_out_valid !== 1'b0) begin errors++; $display("FAIL %s duplicate: out_valid=%b want 0", name, v8_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta   [4] = '{8'h01, 8'h10, 8'h40, 8'hF0};
    logic [7:0] tb_  [4] = '{8'h02, 8'h20, 8'h01, 8'h20};
    logic       tc   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    op_e        to   [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD};
    logic [9:0] texp [4] = '{10'h003, 10'h031, 10'h23F, 10'h210};
    logic [9:0] exp_q[$];
    logic [9:0] got;
    int sent = 0;
    int recv = 0;
    bit saw_full = 1'b0;
    for (int n = 0; n < 40 && recv < 4; n++) begin
      @(negedge clk);
      v8_out_ready = (n >= 5);
      if (sent < 4) begin
        v8_a = ta[sent]; v8_b = tb_[sent]; v8_cin = tc[sent]; v8_op = to[sent]; v8_in_valid = 1'b1;
      end else begin
        v8_in_valid = 1'b0;
      end
      #1;
      if (v8_in_ready === 1'b0) saw_full = 1'b1;
      if (v8_out_valid === 1'b1) begin
        got = {v8_carry, v8_overflow, v8_sum};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b unexpected: got %h want no result", got);
        end else if (got !== exp_q[0]) begin
          errors++; $display("FAIL b2b result %0d: got %h want %h", recv, got, exp_q[0]);
        end
        if (v8_out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          recv++;
        end
      end
      if (v8_in_valid && v8_in_ready) begin
        exp_q.push_back(texp[sent]);
        sent++;
      end
    end
    v8_in_valid = 1'b0;
    checks++;
    if (recv != 4) begin errors++; $display("FAIL b2b count: got %0d want 4", recv); end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL b2b in_ready: got never low want low while full"); end
    @(negedge clk);
    #1;
    checks++;
    if (v8_out_valid !== 1'b0) begin errors++; $display("FAIL b2b duplicate: out_valid=%b want 0", v8_out_valid); end
  endtask

  task automatic test_reset_flush();
    int stale = 0;
    @(negedge clk);
    v8_out_ready = 1'b0;
    v8_a = 8'h11; v8_b = 8'h22; v8_cin = 1'b0; v8_op = OP_ADD; v8_in_valid = 1'b1;
    @(negedge clk);
    v8_a = 8'h40; v8_b = 8'h05;
    @(negedge clk);
    v8_in_valid = 1'b0;
    #1;
    checks++;
    if (v8_out_valid !== 1'b1 || v8_sum !== 8'h33) begin
      errors++; $display("FAIL flush pre-reset: out_valid=%b sum=%h want 1/33", v8_out_valid, v8_sum);
    end
    checks++;
    if (v8_in_ready !== 1'b0) begin errors++; $display("FAIL flush full: in_ready=%b want 0", v8_in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v8_out_ready = 1'b1;
    #1;
    checks++;
    if (v8_out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b want 0", v8_out_valid); end
    checks++;
    if ({v8_carry, v8_overflow, v8_sum} !== 10'h000) begin
      errors++; $display("FAIL flush outputs: got %h want 000", {v8_carry, v8_overflow, v8_sum});
    end
    checks++;
    if (v8_in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b want 1", v8_in_ready); end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      if (v8_out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL flush stale: got %0d results want 0", stale); end
  endtask

  task automatic test_w32_vector(input string name, input logic [31:0] va, input logic [31:0] vb,
                                 input logic vcin, input op_e vop, input logic [33:0] expv);
    int lat;
    @(negedge clk);
    w32_a = va; w32_b = vb; w32_cin = vcin; w32_op = vop; w32_in_valid = 1'b1; w32_out_ready = 1'b1;
    @(negedge clk);
    w32_in_valid = 1'b0; w32_a = 32'h0; w32_b = 32'h0;
    lat = 1;
    #1;
    while (w32_out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (w32_out_valid !== 1'b1 || lat != 4) begin
      errors++; $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    checks++;
    if ({w32_carry, w32_overflow, w32_sum} !== expv) begin
      errors++; $display("FAIL %s result: got %h want %h", name, {w32_carry, w32_overflow, w32_sum}, expv);
    end
  endtask

  task automatic test_s1_vector(input string name, input logic [7:0] va, input logic [7:0] vb,
                                input logic vcin, input op_e vop, input logic [9:0] expv);
    int lat;
    @(negedge clk);
    s1_a = va; s1_b = vb; s1_cin = vcin; s1_op = vop; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
    @(negedge clk);
    s1_in_valid = 1'b0; s1_a = 8'h00; s1_b = 8'h00;
    lat = 1;
    #1;
    while (s1_out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++;
    if (s1_out_valid !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL %s latency: got %0d want 1", name, lat);
    end
    checks++;
    if ({s1_carry, s1_overflow, s1_sum} !== expv) begin
      errors++; $display("FAIL %s result: got %h want %h", name, {s1_carry, s1_overflow, s1_sum}, expv);
    end
  endtask

  task automatic test_random_w32();
    logic [33:0] exp_q[$];
    logic [33:0] got;
    int sent = 0;
    int recv = 0;
    bit pend = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          w32_in_valid = 1'b1; w32_a = $urandom(); w32_b = $urandom();
          w32_cin = 1'($urandom_range(0, 1)); w32_op = op_e'($urandom_range(0, 1));
        end else begin
          w32_in_valid = 1'b0;
        end
      end
      w32_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (w32_out_valid === 1'b1) begin
        got = {w32_carry, w32_overflow, w32_sum};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL w32 unexpected: got %h want no result", got);
        end else if (got !== exp_q[0]) begin
          errors++; $display("FAIL w32 beat %0d: got %h want %h", recv, got, exp_q[0]);
        end
        if (w32_out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          recv++;
        end
      end
      pend = w32_in_valid && !w32_in_ready;
      if (w32_in_valid && w32_in_ready) begin
        exp_q.push_back(ref32(w32_a, w32_b, w32_cin, w32_op));
        sent++;
      end
    end
    w32_in_valid = 1'b0;
    checks++;
    if (recv != 1000) begin errors++; $display("FAIL w32 count: got %0d want 1000", recv); end
  endtask

  task automatic test_random_s1();
    logic [9:0] exp_q[$];
    logic [9:0] got;
    int sent = 0;
    int recv = 0;
    bit pend = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          s1_in_valid = 1'b1; s1_a = 8'($urandom()); s1_b = 8'($urandom());
          s1_cin = 1'($urandom_range(0, 1)); s1_op = op_e'($urandom_range(0, 1));
        end else begin
          s1_in_valid = 1'b0;
        end
      end
      s1_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (s1_out_valid === 1'b1) begin
        got = {s1_carry, s1_overflow, s1_sum};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL s1 unexpected: got %h want no result", got);
        end else if (got !== exp_q[0]) begin
          errors++; $display("FAIL s1 beat %0d: got %h want %h", recv, got, exp_q[0]);
        end
        if (s1_out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          recv++;
        end
      end
      pend = s1_in_valid && !s1_in_ready;
      if (s1_in_valid && s1_in_ready) begin
        exp_q.push_back(ref8(s1_a, s1_b, s1_cin, s1_op));
        sent++;
      end
    end
    s1_in_valid = 1'b0;
    checks++;
    if (recv != 1000) begin errors++; $display("FAIL s1 count: got %0d want 1000", recv); end
  endtask

  initial begin
    rst = 1'b1;
    v8_in_valid = 1'b0;  v8_a = '0;  v8_b = '0;  v8_cin = 1'b0;  v8_op = OP_ADD;  v8_out_ready = 1'b1;
    w32_in_valid = 1'b0; w32_a = '0; w32_b = '0; w32_cin = 1'b0; w32_op = OP_ADD; w32_out_ready = 1'b1;
    s1_in_valid = 1'b0;  s1_a = '0;  s1_b = '0;  s1_cin = 1'b0;  s1_op = OP_ADD;  s1_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    test_reset();
    test_vector("add_ff_01", 8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
    test_vector("add_7f_01", 8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);
    test_vector("add_00_cin", 8'h00, 8'h00, 1'b1, OP_ADD, 8'h01, 1'b0, 1'b0);
    test_vector("sub_05_07", 8'h05, 8'h07, 1'b0, OP_SUB, 8'hFE, 1'b0, 1'b0);
    test_vector("sub_80_01", 8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b1, 1'b1);
    test_vector("sub_cin_ignored", 8'h10, 8'h10, 1'b1, OP_SUB, 8'h00, 1'b1, 1'b0);
    test_vector("add_80_80", 8'h80, 8'h80, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b1);
    test_vector("add_seg_carry", 8'h0F, 8'h01, 1'b0, OP_ADD, 8'h10, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_flush();
    test_w32_vector("w32_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 34'h2_0000_0000);
    test_w32_vector("w32_sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 34'h0_FFFF_FFFF);
    test_w32_vector("w32_add_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 34'h1_8000_0000);
    test_s1_vector("s1_sub_80_01", 8'h80, 8'h01, 1'b0, OP_SUB, 10'h37F);
    test_s1_vector("s1_add_ff_01_cin", 8'hFF, 8'h01, 1'b1, OP_ADD, 10'h201);
    test_random_w32();
    test_random_s1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
